// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit adder processing DIGIT bits per clock with valid/ready handshakes.
// Optional subtract mode when DIGIT_SERIAL_ADDER_SUB_EN is defined (adds a sub input).
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("digit_serial_adder: DIGIT must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [DIGIT:0]   dsum;
   logic             sub_i, last;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   assign dsum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   assign last = cnt_q == CW'(NDIG - 1);

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_sh_d    = sum_sh_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               // subtraction is a + ~b + 1, so the carry register seeds the +1
               a_sh_d     = a;
               b_sh_d     = sub_i ? ~b : b;
               carry_d    = sub_i ? 1'b1 : cin;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            sum_sh_d = (sum_sh_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
            a_sh_d   = a_sh_q >> DIGIT;
            b_sh_d   = b_sh_q >> DIGIT;
            carry_d  = dsum[DIGIT];
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
               sum_d       = sum_sh_d;
               cout_d      = dsum[DIGIT];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_sh_q    <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_sh_q    <= sum_sh_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: scoreboard bench for digit_serial_adder, directed cases plus random traffic.
// Exercises subtract mode too when DIGIT_SERIAL_ADDER_SUB_EN is defined.
module tb_digit_serial_adder;
   localparam int W  = 16;
   localparam int D  = 4;
   localparam int ND = W / D;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      int           acc;
   } exp_t;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         in_valid = 1'b0, in_ready, cin = 1'b0;
   logic         out_valid, out_ready = 1'b1, cout;
   logic [W-1:0] a = '0, b = '0, sum;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   logic         sub = 1'b0;
`endif
   int           n_checks = 0, n_err = 0, cyc = 0;
   bit           rnd_mode = 1'b0, ready_set = 1'b1, ov_prev = 1'b0;
   exp_t         sb[$];
   exp_t         popped;
   logic [W-1:0] held_s;
   logic         held_c;

   logic         w_valid = 1'b0;
   logic [7:0]   wa = 8'hC8, wb = 8'h64;
   logic [2:0]   w_ready, w_ov, w_co;
   logic [7:0]   w_s[3];

   digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout));

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready[0]),
      .a(wa), .b(wb), .cin(1'b0),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(w_ov[0]), .out_ready(1'b1), .sum(w_s[0]), .cout(w_co[0]));

   digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready[1]),
      .a(wa), .b(wb), .cin(1'b0),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(w_ov[1]), .out_ready(1'b1), .sum(w_s[1]), .cout(w_co[1]));

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready[2]),
      .a(wa), .b(wb), .cin(1'b0),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(w_ov[2]), .out_ready(1'b1), .sum(w_s[2]), .cout(w_co[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_set;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference: plain integer arithmetic on the full operands
   function automatic exp_t model(input logic [W-1:0] xa, xb, input logic xc, xs, input int acc);
      exp_t         e;
      logic [W:0]   t;
      t     = xs ? ({1'b0, xa} - {1'b0, xb}) : ({1'b0, xa} + {1'b0, xb} + (W + 1)'(xc));
      e.s   = t[W-1:0];
      e.c   = xs ? (xa >= xb) : t[W];
      e.acc = acc;
      return e;
   endfunction

   task automatic send(input logic [W-1:0] xa, xb, input logic xc, xs);
      int n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = xa;
      b        = xb;
      cin      = xc;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      sub      = xs;
`endif
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      if (!in_ready) begin
         chk("accept_timeout", {31'b0, in_ready}, 1);
         in_valid = 1'b0;
         return;
      end
      sb.push_back(model(xa, xb, xc, xs, cyc + 1));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      chk("out_valid_timeout", {31'b0, out_valid}, 1);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) ov_prev = 1'b0;
      else begin
         if (out_valid) begin
            chk("in_ready_low_in_done", {31'b0, in_ready}, 0);
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL stale_out_valid: out_valid=1 sum=%0h with no outstanding transaction", sum);
            end else begin
               if (!ov_prev) chk("latency", cyc - sb[0].acc, ND);
               else begin
                  chk("hold_sum", {16'b0, sum}, {16'b0, held_s});
                  chk("hold_cout", {31'b0, cout}, {31'b0, held_c});
               end
               if (out_ready) begin
                  popped = sb.pop_front();
                  chk("sum", {16'b0, sum}, {16'b0, popped.s});
                  chk("cout", {31'b0, cout}, {31'b0, popped.c});
               end
            end
            held_s = sum;
            held_c = cout;
         end
         ov_prev = out_valid && !out_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int     c0, n;
      int     exp_lat[3] = '{8, 4, 1};
      bit     seen[3] = '{0, 0, 0};
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_sum", {16'b0, sum}, 0);
      chk("rst_cout", {31'b0, cout}, 0);
      rst_n = 1'b1;
      #1 chk("rel_in_ready_pre_edge", {31'b0, in_ready}, 0);
      @(negedge clk);
      chk("rel_in_ready_post_edge", {31'b0, in_ready}, 1);

      send(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_out();
      @(negedge clk);
      chk("in_ready_after_handshake", {31'b0, in_ready}, 1);
      chk("out_valid_after_handshake", {31'b0, out_valid}, 0);

      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      wait_empty();

      ready_set = 1'b0;
      send(16'h0F0F, 16'h1111, 1'b1, 1'b0);
      in_valid = 1'b1;
      a        = 16'hAAAA;
      b        = 16'h5555;
      wait_out();
      repeat (5) @(negedge clk);
      chk("bp_out_valid_held", {31'b0, out_valid}, 1);
      chk("bp_in_ready_low", {31'b0, in_ready}, 0);
      ready_set = 1'b1;
      send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      wait_empty();

      send(16'h00FF, 16'h0F01, 1'b0, 1'b0);
      repeat (ND) begin
         a = 16'($urandom);
         b = 16'($urandom);
         @(posedge clk);
         #1;
      end
      wait_empty();

      send(16'h1357, 16'h2468, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 0);
      chk("midrst_sum", {16'b0, sum}, 0);
      chk("midrst_cout", {31'b0, cout}, 0);
      chk("midrst_in_ready", {31'b0, in_ready}, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready_after", {31'b0, in_ready}, 1);
      chk("midrst_no_stale", {31'b0, out_valid}, 0);

      if (HAS_SUB) begin
         send(16'h0005, 16'h0007, 1'b0, 1'b1);
         send(16'h0007, 16'h0005, 1'b1, 1'b1);
         wait_empty();
      end

      rnd_mode = 1'b1;
      repeat (150) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                        HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0);
      wait_empty();
      rnd_mode = 1'b0;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (w_ready != 3'b111 && n < 50);
      chk("sweep_ready", {29'b0, w_ready}, 3'b111);
      w_valid = 1'b1;
      c0 = cyc + 1;
      @(posedge clk);
      #1 w_valid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (w_ov[k] && !seen[k]) begin
               seen[k] = 1'b1;
               chk($sformatf("sweep_latency_%0d", k), cyc - c0, exp_lat[k]);
               chk($sformatf("sweep_sum_%0d", k), {24'b0, w_s[k]}, 32'h2C);
               chk($sformatf("sweep_cout_%0d", k), {31'b0, w_co[k]}, 1);
            end
         end
      end
      for (int k = 0; k < 3; k++) chk($sformatf("sweep_seen_%0d", k), {31'b0, seen[k]}, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
